// File: rtl/rr_mux4_pkg.sv
`default_nettype none
// ============================================================================
// Module : rr_mux4_pkg
// Brief  : Shared types, sizes and the round-robin pick helper for rr_mux4.
// Rev    : 1.0  initial release
// ============================================================================
package rr_mux4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef struct packed {
    logic     found;
    req_idx_t idx;
  } pick_t;

  // Scans from the farthest offset down so the nearest requester to ptr wins.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input req_idx_t           ptr);
    pick_t    r;
    req_idx_t c;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = ptr + req_idx_t'(k);
      if (req[c]) begin
        r.found = 1'b1;
        r.idx   = c;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux2.sv
`default_nettype none
// ============================================================================
// Module : mux2
// Brief  : W-bit 2:1 multiplexer.
// Rev    : 1.0  initial release
// ============================================================================
module mux2 #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule
`default_nettype wire

// File: rtl/mux4.sv
`default_nettype none
// ============================================================================
// Module : mux4
// Brief  : W-bit 4:1 multiplexer built as a tree of 2:1 muxes.
// Rev    : 1.0  initial release
// ============================================================================
module mux4 #(
  parameter int W = 4
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  logic [W-1:0] w_lo;
  logic [W-1:0] w_hi;

  mux2 #(.W(W)) u_lo  (.a(d0),   .b(d1),   .sel(sel[0]), .y(w_lo));
  mux2 #(.W(W)) u_hi  (.a(d2),   .b(d3),   .sel(sel[0]), .y(w_hi));
  mux2 #(.W(W)) u_top (.a(w_lo), .b(w_hi), .sel(sel[1]), .y(y));

endmodule
`default_nettype wire

// File: rtl/rr_grant_4.sv
`default_nettype none
// ============================================================================
// Module : rr_grant_4
// Brief  : Combinational round-robin pick of one of four requesters.
// Rev    : 1.0  initial release
// ============================================================================
module rr_grant_4
  import rr_mux4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output req_idx_t           winner,
  output logic               any_req
);

  pick_t w_pick;

  always_comb begin
    w_pick = rr_pick(req, ptr);
  end

  assign winner  = w_pick.idx;
  assign any_req = w_pick.found;

endmodule
`default_nettype wire

// File: rtl/rr_mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_mux4_arbiter
// Brief  : Round-robin arbiter driving a shared 4:1 mux into a one-entry
//          valid/ready output slot.
// Rev    : 1.0  initial release
// ============================================================================
module rr_mux4_arbiter
  import rr_mux4_pkg::*;
#(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [W-1:0]       d0,
  input  logic [W-1:0]       d1,
  input  logic [W-1:0]       d2,
  input  logic [W-1:0]       d3,
  output logic [NUM_REQ-1:0] ack,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [IDX_W-1:0]   out_src,
  input  logic               out_ready
);

  req_idx_t     r_ptr;
  req_idx_t     w_winner;
  logic         w_any;
  logic         w_can_load;
  logic         w_load;
  logic [W-1:0] w_mux_data;

  rr_grant_4 u_grant (
    .req     (req),
    .ptr     (r_ptr),
    .winner  (w_winner),
    .any_req (w_any)
  );

  mux4 #(.W(W)) u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (w_winner),
    .y   (w_mux_data)
  );

  // The slot can take a new word when empty or when it is drained this cycle.
  assign w_can_load = !out_valid || out_ready;
  assign w_load     = w_can_load && w_any;
  assign ack        = (w_load && !rst) ?
                      ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      r_ptr     <= '0;
    end else if (w_load) begin
      out_valid <= 1'b1;
      out_data  <= w_mux_data;
      out_src   <= w_winner;
      r_ptr     <= req_idx_t'(w_winner + 1'b1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/rr_mux4_arbiter.md
# rr_mux4_arbiter

Round-robin arbiter and sequencer for the 4:1 data multiplexer. It accepts up to four competing requesters and selects one per cycle. It drives the mux select and registers the chosen word into a single-entry output slot with a valid/ready handshake. It sits between four producer ports and one downstream consumer, so the shared 4:1 datapath can be used without software-managed select lines.

## Interface
- W, default 4: data width of each requester word and of the output. It must equal the width of the 4:1 mux datapath.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  per-requester request; bit i means word d_i is offered.
- d0, d1, d2, d3  in  W each  requester data words.
- ack  out  4  per-requester accept, one-hot or zero; a transfer from i happens in any cycle with req[i] && ack[i].
- out_valid  out  1  output slot holds a word.
- out_data  out  W  registered selected word.
- out_src  out  2  index of the requester that supplied out_data.
- out_ready  in  1  consumer accepts out_data this cycle when out_valid is high.

## Operation
- State: output slot (out_valid, out_data, out_src) and a 2-bit priority pointer ptr.
- can_load = !out_valid || out_ready.
- Winner selection:
  - Winner = the first i with req[i] set, searching ptr, ptr+1, ptr+2, ptr+3 with mod-4 wrap.
  - Selection is combinational.
  - The winner index drives the 4:1 mux select, so sel = winner.
- ack = onehot(winner) when can_load && |req && !rst; otherwise ack = 4'b0000.
- On a load (can_load && |req):
  - out_data <= mux(d0..d3, winner), out_src <= winner, out_valid <= 1.
  - ptr <= winner + 1 (mod 4).
- No load, consumer takes the word (out_valid && out_ready && !(|req)): out_valid <= 0. out_data and out_src hold their last values.
- Stall (out_valid && !out_ready):
  - The slot, out_data and out_src are frozen.
  - ptr is unchanged and ack = 0.
  - Requesters keep req asserted and their data stable.
- Simultaneous consume and load in the same cycle is legal. The slot is overwritten with the new word, so throughput is 1 word per cycle.
- A requester that deasserts req before it is acked loses nothing. ptr advances only on grants.
- Fairness: a requester holding req continuously is granted within at most 4 consecutive loads.
- Reset (asynchronous, any time, including mid-stall):
  - out_valid = 0, out_data = 0, out_src = 0, ptr = 0, ack = 0.
  - Any word in the slot is discarded.
  - On the first edge after rst drops, normal arbitration resumes from ptr = 0.

## Timing
- Latency: a word acked in cycle N appears with out_valid = 1 in cycle N+1.
- ack depends combinationally on req, out_valid, out_ready and ptr. There are no combinational paths from d* to ack.
- out_data, out_src and out_valid are driven directly from flops, with no combinational output path.
- Back-to-back: with out_ready held high and req held at 4'b1111, grants go 0,1,2,3,0,… one per cycle.
- Boundary behaviour:
  - ptr = 3 with winner 3 wraps ptr to 0.
  - req = 0 with an empty slot leaves ptr untouched and out_valid at 0.

## Structure
- Package rr_mux4_pkg holds:
  - NUM_REQ = 4 and IDX_W = 2.
  - typedef req_idx_t (logic [IDX_W-1:0]).
  - function rr_pick(req, ptr), returning the winner index and a found flag.
- Sub-module rr_grant_4: pure combinational round-robin pick from req and ptr, producing the winner index and an any-request flag. It is reused by the block and unit-tested on its own.
- Datapath: instantiate the team's existing 4:1 mux, built from 2:1 muxes, with sel = winner. The top level holds the slot and ptr flops.

## Test plan
- Reset mid-operation:
  - Stimulus: assert rst while out_valid = 1 and ptr = 2.
  - Required: out_valid, out_data, out_src and ack all read 0 immediately, before the next edge.
  - After release, req = 4'b1111 grants source 0 first.
- Full contention:
  - Stimulus: req = 4'b1111, d0..d3 = 4'hA, 4'hB, 4'hC, 4'hD, out_ready = 1.
  - Required: out_src sequence 0,1,2,3,0 and out_data sequence A,B,C,D,A on consecutive cycles.
- Stall:
  - Stimulus: out_valid = 1 with out_data = 4'h5, then out_ready = 0 for 3 cycles while req = 4'b0110.
  - Required: ack = 0 and out_data = 4'h5 stable throughout.
  - When out_ready rises, the word is consumed and source 1 loads in the same cycle.
- Wrap and skip:
  - Stimulus: ptr = 3 with req = 4'b0101.
  - Required: winner is 0, then ptr = 1; the next grant goes to 2.
- Idle drain:
  - Stimulus: a single req pulse on source 3 with d3 = 4'h7, then req = 0.
  - Required: out_valid = 1 with out_data = 4'h7 and out_src = 3 for one cycle; out_valid = 0 after consumption.
  - ptr = 0 afterwards.
- Fairness soak:
  - Stimulus: random req patterns with random out_ready for 10k cycles.
  - Required: no continuously requesting source waits more than 4 loads.
  - ack is always one-hot or zero, and never asserted while out_valid && !out_ready.
